// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared slice width and FSM state type for the nibble-serial adder
package add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_4.sv
// rtl/add_4.sv - 4-bit ripple slice with carry in/out
module add_4 (
  input  logic       cin,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] sum,
  output logic       co
);

  assign {co, sum} = {1'b0, A} + {1'b0, B} + {4'b0000, cin};

endmodule

// File: rtl/add_nibble_seq.sv
// rtl/add_nibble_seq.sv - nibble-serial A+B+cin adder with valid/ready handshakes
// ADD_NIBBLE_SEQ_OVF_EN enables the signed overflow flag; otherwise ovf is tied 0.
import add_pkg::*;

module add_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] A,
  input  logic [NIBBLE_W*NIBBLES-1:0] B,
  input  logic                        cin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        co,
  output logic                        ovf
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d, co_q, co_d;
  logic [NIBBLE_W-1:0] a_nib, b_nib, slice_sum;
  logic               slice_co, last_nib;

  add_4 u_slice (
    .cin (carry_q),
    .A   (a_nib),
    .B   (b_nib),
    .sum (slice_sum),
    .co  (slice_co)
  );

  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  // Select the operand nibble addressed by the running index.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

`ifdef ADD_NIBBLE_SEQ_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    co_d    = co_q;
`ifdef ADD_NIBBLE_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          co_d    = 1'b0;
`ifdef ADD_NIBBLE_SEQ_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[i*NIBBLE_W +: NIBBLE_W] = slice_sum;
        end
        carry_d = slice_co;
        idx_d   = idx_q + IDX_W'(1);
        if (last_nib) begin
          co_d    = slice_co;
`ifdef ADD_NIBBLE_SEQ_OVF_EN
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (slice_sum[NIBBLE_W-1] != a_q[W-1]);
`endif
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      co_q    <= co_d;
    end
  end

`ifdef ADD_NIBBLE_SEQ_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign co        = co_q;

endmodule

// File: tb/tb_add_nibble_seq.sv
// tb/tb_add_nibble_seq.sv - directed-vector self-checking bench for add_nibble_seq
module tb_add_nibble_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, cin, co, ovf;
  logic [15:0] A, B, sum;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;

  add_nibble_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .co(co), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef ADD_NIBBLE_SEQ_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) check("in_ready_timeout", 0, 1);
  endtask

  task automatic wait_out_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  // Accept one operand set, check latency and result, leave it parked in DONE.
  task automatic run_txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic [15:0] es, input logic eco, input logic eovf);
    int lat;
    wait_in_ready();
    A = a; B = b; cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; A = 16'hDEAD; B = 16'hBEEF; cin = ~c;
    wait_out_valid(lat);
    check({tag, "_lat"}, lat, 4);
    check({tag, "_sum"}, sum, es);
    check({tag, "_co"},  co,  eco);
    check({tag, "_ovf"}, ovf, eovf & OVF_ON);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_out_valid", out_valid, 0);
    check("drain_in_ready",  in_ready,  1);
  endtask

  logic [15:0] bb_a   [4] = '{16'h0001, 16'h8000, 16'hABCD, 16'hF0F0};
  logic [15:0] bb_b   [4] = '{16'h0002, 16'h8000, 16'h1111, 16'h0F0F};
  logic        bb_c   [4] = '{1'b0,     1'b0,     1'b1,     1'b1};
  logic [15:0] bb_s   [4] = '{16'h0003, 16'h0000, 16'hBCDF, 16'h0000};
  logic        bb_co  [4] = '{1'b0,     1'b1,     1'b0,     1'b1};
  logic        bb_ovf [4] = '{1'b0,     1'b1,     1'b0,     1'b0};

  initial begin
    int lat;
    int prev_acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; cin = 1'b0;
    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_co", co, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);

    run_txn("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    drain();
    run_txn("cin1", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    drain();

    // Stall in DONE with stray in_valid pulses.
    run_txn("ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; A = 16'h0F0F; B = 16'h0101;
      tick();
      check("stall_out_valid", out_valid, 1);
      check("stall_sum", sum, 16'h8000);
      check("stall_co", co, 0);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    drain();

    // Reset two cycles into RUN discards the operation.
    A = 16'h1111; B = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    tick();
    rst = 1'b0;
    tick();
    check("midrst_in_ready", in_ready, 1);
    check("midrst_no_result", out_valid, 0);
    run_txn("after_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
    drain();

    // Back-to-back: in_valid and out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prev_acc  = 0;
    for (int k = 0; k < 4; k++) begin
      A = bb_a[k]; B = bb_b[k]; cin = bb_c[k];
      wait_in_ready();
      if (k > 0) check("b2b_period", cyc - prev_acc, 6);
      prev_acc = cyc;
      tick();
      wait_out_valid(lat);
      check("b2b_lat", lat, 4);
      check("b2b_sum", sum, bb_s[k]);
      check("b2b_co", co, bb_co[k]);
      check("b2b_ovf", ovf, bb_ovf[k] & OVF_ON);
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("b2b_end_in_ready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/add_nibble_seq.md
ADD_NIBBLE_SEQ -- requirements
Module: add_nibble_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, number of 4-bit slices per operand (operand width W = 4*NIBBLES, NIBBLES >= 1).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operands A, B, cin presented.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port A  input  W  operand A.
REQ-007 SHALL have port B  input  W  operand B.
REQ-008 SHALL have port cin  input  1  carry into least-significant nibble.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port sum  output  W  result A+B+cin modulo 2^W.
REQ-012 SHALL have port co  output  1  carry out of the most-significant nibble.
REQ-013 SHALL have port ovf  output  1  signed (two's-complement) overflow flag.

Function
REQ-014 SHALL implement FSM with states IDLE, RUN, DONE; IDLE after reset.
REQ-015 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-016 SHALL, on an edge with in_valid && in_ready, capture A, B, cin into internal registers, clear nibble index to 0, and go to RUN.
REQ-017 SHALL, in RUN, add exactly one nibble per cycle (LSB first) through one 4-bit adder slice, feeding the registered carry into the slice cin and storing slice sum into sum[4i+3:4i].
REQ-018 SHALL, on the RUN edge with index NIBBLES-1, register final carry into co, compute ovf, and go to DONE.
REQ-019 SHALL assert out_valid exactly NIBBLES cycles after the accept edge (NIBBLES=4: 4 cycles); no earlier visibility required.
REQ-020 SHALL hold sum, co, ovf, out_valid stable in DONE while out_ready is low.
REQ-021 SHALL, on an edge with out_valid && out_ready, go to IDLE; in_ready rises the following cycle (no accept/complete overlap).
REQ-022 SHALL ignore in_valid in RUN and DONE; A, B, cin may change freely after the accept edge.
REQ-023 SHALL compute ovf = (A[W-1]==B[W-1]) && (sum[W-1]!=A[W-1]) from captured operands.
REQ-024 SHALL wrap modulo 2^W; carry out of the top nibble appears only on co.

Reset
REQ-025 SHALL, on rst high, immediately (asynchronously) force state IDLE, in_ready 1 after release, out_valid 0, sum 0, co 0, ovf 0, index 0, internal carry 0.
REQ-026 SHALL discard any in-flight operation on reset mid-RUN or mid-DONE; no result is produced for it.

Configuration
REQ-027 SHALL use macro ADD_NIBBLE_SEQ_OVF_EN: defined -> ovf per REQ-023; undefined -> ovf port retained but tied 0 and its logic removed.

Structure
REQ-028 SHALL place NIBBLE_W=4 and the FSM state typedef (IDLE, RUN, DONE) in shared package add_pkg.
REQ-029 SHALL instantiate the existing add_4 module as its single sub-module (ports cin, A, B, sum, co) for the per-nibble add.
REQ-030 SHALL contain no other arithmetic wider than the 4-bit slice besides the index counter.

Verification (NIBBLES=4)
REQ-031 SHALL cover: A=0xFFFF, B=0x0001, cin=0 -> after 4 cycles out_valid=1, sum=0x0000, co=1, ovf=0.
REQ-032 SHALL cover: A=0x1234, B=0x4321, cin=1 -> sum=0x5556, co=0, ovf=0.
REQ-033 SHALL cover: A=0x7FFF, B=0x0001, cin=0 -> sum=0x8000, co=0, ovf=1 with macro, ovf=0 without.
REQ-034 SHALL cover: out_ready held low 5 cycles in DONE -> out_valid, sum, co stable, in_ready=0; in_valid pulses meanwhile ignored.
REQ-035 SHALL cover: rst pulsed 2 cycles after accept -> out_valid=0, sum=0 immediately; in_ready=1 after release; next A=0x0003, B=0x0004 yields 0x0007.
REQ-036 SHALL cover: back-to-back transactions with out_ready and in_valid held high -> one accept every NIBBLES+2 cycles, every result correct.
